// File: rtl/smart_toilet_dose_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : smart_toilet_dose_sequencer                                    |
// | Brief   : Staggered inlet-valve dosing sequencer for the smart_toilet    |
// |           fluidic netlist: soln3 -> +soln2 -> +soln1 -> flush -> done.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module smart_toilet_dose_sequencer #(
   parameter int CNT_W        = 16,
   parameter int FLUSH_CYCLES = 64,
   parameter int RUN_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [CNT_W-1:0] cfg_lead3,
   input  logic [CNT_W-1:0] cfg_lead2,
   input  logic [CNT_W-1:0] cfg_mix,
   input  logic             abort,
   output logic             valve_soln1,
   output logic             valve_soln2,
   output logic             valve_soln3,
   output logic             valve_flush,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             cfg_err,
   output logic [RUN_W-1:0] run_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD3 = 3'd1,
      S_LEAD2 = 3'd2,
      S_MIX   = 3'd3,
      S_FLUSH = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] c_flush_load = CNT_W'(FLUSH_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_timer, w_timer_nxt;
   logic [CNT_W-1:0] r_lead2, w_lead2_nxt;
   logic [CNT_W-1:0] r_mix,   w_mix_nxt;
   logic             r_abort_flag, w_abort_flag_nxt;
   logic             w_cfg_err_nxt;
   logic             w_accept;
   logic             w_timer_zero;
   logic             w_run_inc;

   logic             r_start_ready, r_busy, r_done, r_aborted, r_cfg_err;
   logic             r_v1, r_v2, r_v3, r_vf;
   logic [RUN_W-1:0] r_run_count;

   // A zero-length phase still lasts one cycle, so the load value is max(len,1)-1.
   function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

   assign w_accept     = start_valid & r_start_ready;
   assign w_timer_zero = (r_timer == '0);
   assign w_run_inc    = (r_state == S_FLUSH) && (w_state_nxt == S_DONE) && !w_abort_flag_nxt;

   // Next-state, phase timer and latched-configuration logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_timer_nxt      = r_timer;
      w_lead2_nxt      = r_lead2;
      w_mix_nxt        = r_mix;
      w_abort_flag_nxt = r_abort_flag;
      w_cfg_err_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (cfg_mix != '0) begin
                  w_state_nxt      = S_LEAD3;
                  w_timer_nxt      = len_m1(cfg_lead3);
                  w_lead2_nxt      = cfg_lead2;
                  w_mix_nxt        = cfg_mix;
                  w_abort_flag_nxt = 1'b0;
               end else begin
                  w_cfg_err_nxt = 1'b1;
               end
            end
         end
         S_LEAD3: begin
            if (abort) begin
               w_state_nxt      = S_FLUSH;
               w_timer_nxt      = c_flush_load;
               w_abort_flag_nxt = 1'b1;
            end else if (w_timer_zero) begin
               w_state_nxt = S_LEAD2;
               w_timer_nxt = len_m1(r_lead2);
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         S_LEAD2: begin
            if (abort) begin
               w_state_nxt      = S_FLUSH;
               w_timer_nxt      = c_flush_load;
               w_abort_flag_nxt = 1'b1;
            end else if (w_timer_zero) begin
               w_state_nxt = S_MIX;
               w_timer_nxt = len_m1(r_mix);
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         S_MIX: begin
            if (abort) begin
               w_state_nxt      = S_FLUSH;
               w_timer_nxt      = c_flush_load;
               w_abort_flag_nxt = 1'b1;
            end else if (w_timer_zero) begin
               w_state_nxt = S_FLUSH;
               w_timer_nxt = c_flush_load;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         S_FLUSH: begin
            if (w_timer_zero) begin
               w_state_nxt = S_DONE;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, timer and registered outputs; outputs are decoded from the next state so they
   // change on the same edge as the state and valves close immediately on async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_lead2       <= '0;
         r_mix         <= '0;
         r_abort_flag  <= 1'b0;
         r_start_ready <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         r_cfg_err     <= 1'b0;
         r_v1          <= 1'b0;
         r_v2          <= 1'b0;
         r_v3          <= 1'b0;
         r_vf          <= 1'b0;
         r_run_count   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_timer       <= w_timer_nxt;
         r_lead2       <= w_lead2_nxt;
         r_mix         <= w_mix_nxt;
         r_abort_flag  <= w_abort_flag_nxt;
         r_start_ready <= (w_state_nxt == S_IDLE);
         r_busy        <= (w_state_nxt != S_IDLE);
         r_done        <= (w_state_nxt == S_DONE);
         r_aborted     <= (w_state_nxt == S_DONE) && w_abort_flag_nxt;
         r_cfg_err     <= w_cfg_err_nxt;
         r_v1          <= (w_state_nxt == S_MIX);
         r_v2          <= (w_state_nxt == S_MIX) || (w_state_nxt == S_LEAD2);
         r_v3          <= (w_state_nxt == S_MIX) || (w_state_nxt == S_LEAD2) ||
                          (w_state_nxt == S_LEAD3);
         r_vf          <= (w_state_nxt == S_FLUSH);
         if (w_run_inc) begin
            r_run_count <= r_run_count + 1'b1;
         end
      end
   end

   assign start_ready = r_start_ready;
   assign busy        = r_busy;
   assign done        = r_done;
   assign aborted     = r_aborted;
   assign cfg_err     = r_cfg_err;
   assign valve_soln1 = r_v1;
   assign valve_soln2 = r_v2;
   assign valve_soln3 = r_v3;
   assign valve_flush = r_vf;
   assign run_count   = r_run_count;

endmodule
`default_nettype wire

// File: tb/tb_smart_toilet_dose_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_smart_toilet_dose_sequencer                                 |
// | Brief   : Self-checking bench for smart_toilet_dose_sequencer.           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_smart_toilet_dose_sequencer;

   localparam int CNT_W = 16;
   localparam int F     = 5;
   localparam int RUN_W = 8;

   logic             clk;
   logic             rst_n;
   logic             start_valid;
   logic             start_ready;
   logic [CNT_W-1:0] cfg_lead3, cfg_lead2, cfg_mix;
   logic             abort;
   logic             valve_soln1, valve_soln2, valve_soln3, valve_flush;
   logic             busy, done, aborted, cfg_err;
   logic [RUN_W-1:0] run_count;

   typedef struct {
      int lat;
      int s1;
      int s2;
      int s3;
      int fl;
      int ab;
      int rc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_rc = 0;

   smart_toilet_dose_sequencer #(
      .CNT_W(CNT_W), .FLUSH_CYCLES(F), .RUN_W(RUN_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .cfg_lead3(cfg_lead3), .cfg_lead2(cfg_lead2), .cfg_mix(cfg_mix),
      .abort(abort),
      .valve_soln1(valve_soln1), .valve_soln2(valve_soln2),
      .valve_soln3(valve_soln3), .valve_flush(valve_flush),
      .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err),
      .run_count(run_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One dose run starting at a negedge in IDLE; ab_n>0 aborts in the ab_n-th MIX cycle.
   task automatic run_dose(input int l3, input int l2, input int m, input int ab_n,
                           input bit hold);
      exp_t e, g;
      int   e3, e2, em, kab, s1, s2, s3, fl, ovl;
      bit   got;
      e3 = (l3 == 0) ? 1 : l3;
      e2 = (l2 == 0) ? 1 : l2;
      em = (m  == 0) ? 1 : m;
      kab = e3 + e2 + ab_n;
      if (ab_n == 0) begin
         e.lat = e3 + e2 + em + F + 1;
         e.s1 = em; e.s2 = e2 + em; e.s3 = e3 + e2 + em;
         e.ab = 0;
         exp_rc = (exp_rc + 1) % (1 << RUN_W);
      end else begin
         e.lat = kab + F + 1;
         e.s1 = ab_n; e.s2 = e2 + ab_n; e.s3 = e3 + e2 + ab_n;
         e.ab = 1;
      end
      e.fl = F;
      e.rc = exp_rc;
      sbq.push_back(e);
      chk("start_ready_idle", int'(start_ready), 1);
      cfg_lead3 = CNT_W'(l3); cfg_lead2 = CNT_W'(l2); cfg_mix = CNT_W'(m);
      start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start_valid = 1'b0;
      cfg_lead3 = 16'd7; cfg_lead2 = 16'd7; cfg_mix = 16'd7;
      s1 = 0; s2 = 0; s3 = 0; fl = 0; ovl = 0; got = 0;
      for (int k = 1; k <= 500 && !got; k++) begin
         s1 += int'(valve_soln1); s2 += int'(valve_soln2);
         s3 += int'(valve_soln3); fl += int'(valve_flush);
         if ((valve_soln1 | valve_soln2 | valve_soln3) & valve_flush) ovl++;
         abort = (ab_n != 0) && (k == kab);
         if (done === 1'b1) begin
            got = 1;
            g = sbq.pop_front();
            chk("done_latency", k, g.lat);
            chk("soln1_cycles", s1, g.s1);
            chk("soln2_cycles", s2, g.s2);
            chk("soln3_cycles", s3, g.s3);
            chk("flush_cycles", fl, g.fl);
            chk("aborted_flag", int'(aborted), g.ab);
            chk("run_count", int'(run_count), g.rc);
            chk("valve_overlap", ovl, 0);
            chk("ready_in_done", int'(start_ready), 0);
         end else begin
            @(negedge clk);
         end
      end
      abort = 1'b0;
      if (!got) begin
         chk("done_timeout", 0, 1);
         if (sbq.size() > 0) void'(sbq.pop_front());
      end
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("done_single_pulse", int'(done), 0);
   endtask

   initial begin
      rst_n = 1'b0; start_valid = 1'b0; abort = 1'b0;
      cfg_lead3 = '0; cfg_lead2 = '0; cfg_mix = '0;
      repeat (3) @(negedge clk);
      chk("rst_start_ready", int'(start_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_valves", int'({valve_soln1, valve_soln2, valve_soln3, valve_flush}), 0);
      chk("rst_run_count", int'(run_count), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // nominal staggered run and minimal-length run
      run_dose(3, 2, 4, 0, 1'b0);
      run_dose(0, 0, 1, 0, 1'b0);

      // zero mix length is rejected with a single cfg_err pulse
      cfg_lead3 = 16'd2; cfg_lead2 = 16'd2; cfg_mix = 16'd0; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err), 1);
      chk("cfg_err_busy", int'(busy), 0);
      chk("cfg_err_valves", int'({valve_soln1, valve_soln2, valve_soln3, valve_flush}), 0);
      @(negedge clk);
      chk("cfg_err_cleared", int'(cfg_err), 0);
      chk("cfg_err_still_idle", int'(busy), 0);

      // abort during the second MIX cycle
      run_dose(3, 2, 4, 2, 1'b0);

      // asynchronous reset in the middle of LEAD2
      cfg_lead3 = 16'd2; cfg_lead2 = 16'd4; cfg_mix = 16'd3; start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("lead2_soln2_open", int'(valve_soln2), 1);
      chk("lead2_soln1_closed", int'(valve_soln1), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valves", int'({valve_soln1, valve_soln2, valve_soln3, valve_flush}), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_run_count", int'(run_count), 0);
      exp_rc = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", int'(start_ready), 1);

      // start_valid held through back-to-back runs; run_count wraps after 256
      for (int r = 0; r < 256; r++) begin
         run_dose(0, 0, 1, 0, 1'b1);
      end
      start_valid = 1'b0;
      chk("run_count_wrap", int'(run_count), 0);
      chk("scoreboard_empty", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
